// File: rtl/jeff_alu181_pkg.sv
// Shared constants for the nibble-serial 74x181-style ALU: select codes, FSM states, slice math.
package jeff_alu181_pkg;

    localparam logic [3:0] SEL_ADD = 4'b1001;
    localparam logic [3:0] SEL_SUB = 4'b0110;
    localparam logic [3:0] SEL_XOR = 4'b0110;  // with m=1
    localparam logic [3:0] SEL_A   = 4'b1111;  // with m=1

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    function automatic int slice_count(input int width);
        return width / 4;
    endfunction

    function automatic int count_bits(input int slices);
        return (slices > 1) ? $clog2(slices) : 1;
    endfunction

endpackage

// File: rtl/jeff_alu181_slice.sv
// Combinational 4-bit 74x181 slice, active-high data; carry chain is independent of m.
// JEFF_ALU181_OVF_EN adds cmsb, the carry into bit 3, for overflow detection.
module jeff_alu181_slice
    import jeff_alu181_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic [3:0] s,
    input  logic       m,
    input  logic       cin,
    output logic [3:0] f,
    output logic       cout,
`ifdef JEFF_ALU181_OVF_EN
    output logic       cmsb,
`endif
    output logic       allones
);

    logic [3:0] x;
    logic [3:0] y;
    logic [4:0] sum;

    // y is always a subset of x, so x+y+cin reproduces the device's P/G carry lookahead
    assign x   = a | (b & {4{s[0]}}) | (~b & {4{s[1]}});
    assign y   = (a & b & {4{s[3]}}) | (a & ~b & {4{s[2]}});
    assign sum = {1'b0, x} + {1'b0, y} + {4'b0000, cin};

    assign f       = m ? ~(x ^ y) : sum[3:0];
    assign cout    = sum[4];
    assign allones = &f;
`ifdef JEFF_ALU181_OVF_EN
    assign cmsb    = sum[3] ^ x[3] ^ y[3];
`endif

endmodule

// File: rtl/jeff_alu181_serial.sv
// Nibble-serial 74x181-style ALU: one 4-bit slice per clock, low slice first, carry held between slices.
// Optional JEFF_ALU181_OVF_EN adds a two's-complement overflow output.
module jeff_alu181_serial
    import jeff_alu181_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       s,
    input  logic             m,
    input  logic             ci_bar,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] f,
    output logic             co_bar,
    output logic             aeqb
`ifdef JEFF_ALU181_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int SLICES = slice_count(WIDTH);
    localparam int CW     = count_bits(SLICES);

    state_t           state, state_nx;
    logic [CW-1:0]    cnt;
    logic [CW+1:0]    base;
    logic [WIDTH-1:0] a_q, b_q, f_q;
    logic [3:0]       s_q;
    logic             m_q, carry_q, acc_q, done_q, co_bar_q, aeqb_q;
    logic             accept, last;
    logic [3:0]       sl_f;
    logic             sl_cout, sl_all;
`ifdef JEFF_ALU181_OVF_EN
    logic             sl_cmsb, ovf_q;
`endif

    assign accept = (state == IDLE) && start;
    assign last   = (state == RUN) && (cnt == CW'(SLICES - 1));
    assign base   = {cnt, 2'b00};

    jeff_alu181_slice u_slice (
        .a       (a_q[base +: 4]),
        .b       (b_q[base +: 4]),
        .s       (s_q),
        .m       (m_q),
        .cin     (carry_q),
        .f       (sl_f),
        .cout    (sl_cout),
`ifdef JEFF_ALU181_OVF_EN
        .cmsb    (sl_cmsb),
`endif
        .allones (sl_all)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = RUN;
            RUN:     if (last)  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q      <= '0;
            b_q      <= '0;
            s_q      <= '0;
            m_q      <= 1'b0;
            cnt      <= '0;
            carry_q  <= 1'b0;
            acc_q    <= 1'b0;
            f_q      <= '0;
            done_q   <= 1'b0;
            co_bar_q <= 1'b1;
            aeqb_q   <= 1'b0;
`ifdef JEFF_ALU181_OVF_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            if (accept) begin
                a_q     <= a;
                b_q     <= b;
                s_q     <= s;
                m_q     <= m;
                carry_q <= ~ci_bar;
                cnt     <= '0;
                acc_q   <= 1'b1;
`ifdef JEFF_ALU181_OVF_EN
                ovf_q   <= 1'b0;
`endif
            end else if (state == RUN) begin
                f_q[base +: 4] <= sl_f;
                carry_q        <= sl_cout;
                acc_q          <= acc_q & sl_all;
                cnt            <= cnt + 1'b1;
                if (last) begin
                    done_q   <= 1'b1;
                    co_bar_q <= ~sl_cout;
                    aeqb_q   <= acc_q & sl_all;
`ifdef JEFF_ALU181_OVF_EN
                    ovf_q    <= ~m_q & (sl_cmsb ^ sl_cout);
`endif
                end
            end
        end
    end

    assign busy   = (state == RUN);
    assign done   = done_q;
    assign f      = f_q;
    assign co_bar = co_bar_q;
    assign aeqb   = aeqb_q;
`ifdef JEFF_ALU181_OVF_EN
    assign ovf    = ovf_q;
`endif

endmodule

// File: tb/tb_jeff_alu181_serial.sv
// Self-checking bench for jeff_alu181_serial (WIDTH=16): spec vectors, randomized ops vs. a function-table model,
// ignored-start, back-to-back and reset-abort sequences. Define JEFF_ALU181_OVF_EN to also check ovf.
module tb_jeff_alu181_serial;

    localparam int W = 16;

    logic         clk, rst_n, start, m, ci_bar;
    logic [W-1:0] a, b;
    logic [3:0]   s;
    logic         busy, done, co_bar, aeqb;
    logic [W-1:0] f;
`ifdef JEFF_ALU181_OVF_EN
    logic         ovf;
`endif

    int checks = 0;
    int errors = 0;

    jeff_alu181_serial #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .a      (a),
        .b      (b),
        .s      (s),
        .m      (m),
        .ci_bar (ci_bar),
        .busy   (busy),
        .done   (done),
        .f      (f),
        .co_bar (co_bar),
        .aeqb   (aeqb)
`ifdef JEFF_ALU181_OVF_EN
        ,
        .ovf    (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] f;
        logic         co_bar;
        logic         aeqb;
        logic         ovf;
    } res_t;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [3:0]   s;
        logic         m;
        logic         ci_bar;
        logic [W-1:0] ef;
        logic         eco_bar;
        logic         eaeqb;
    } vec_t;

    // Datasheet function table: arithmetic result is term1 PLUS term2 PLUS carry.
    function automatic res_t model(input logic [W-1:0] ai, input logic [W-1:0] bi,
                                   input logic [3:0] si, input logic mi, input logic cib);
        res_t         r;
        logic [W:0]   t1, t2, sum;
        logic [W-1:0] lo, ones, lf;
        logic         cin;
        ones = '1;
        cin  = ~cib;
        t2   = '0;
        case (si)
            4'h0: begin t1 = {1'b0, ai};        t2 = '0;                end
            4'h1: begin t1 = {1'b0, ai | bi};   t2 = '0;                end
            4'h2: begin t1 = {1'b0, ai | ~bi};  t2 = '0;                end
            4'h3: begin t1 = {1'b0, ones};      t2 = '0;                end
            4'h4: begin t1 = {1'b0, ai};        t2 = {1'b0, ai & ~bi};  end
            4'h5: begin t1 = {1'b0, ai | bi};   t2 = {1'b0, ai & ~bi};  end
            4'h6: begin t1 = {1'b0, ai};        t2 = {1'b0, ~bi};       end
            4'h7: begin t1 = {1'b0, ones};      t2 = {1'b0, ai & ~bi};  end
            4'h8: begin t1 = {1'b0, ai};        t2 = {1'b0, ai & bi};   end
            4'h9: begin t1 = {1'b0, ai};        t2 = {1'b0, bi};        end
            4'hA: begin t1 = {1'b0, ai | ~bi};  t2 = {1'b0, ai & bi};   end
            4'hB: begin t1 = {1'b0, ones};      t2 = {1'b0, ai & bi};   end
            4'hC: begin t1 = {1'b0, ai};        t2 = {1'b0, ai};        end
            4'hD: begin t1 = {1'b0, ai | bi};   t2 = {1'b0, ai};        end
            4'hE: begin t1 = {1'b0, ai | ~bi};  t2 = {1'b0, ai};        end
            default: begin t1 = {1'b0, ones};   t2 = {1'b0, ai};        end
        endcase
        sum = t1 + t2 + {{W{1'b0}}, cin};
        lo  = {1'b0, t1[W-2:0]} + {1'b0, t2[W-2:0]} + {{(W-1){1'b0}}, cin};
        case (si)
            4'h0: lf = ~ai;
            4'h1: lf = ~(ai | bi);
            4'h2: lf = ~ai & bi;
            4'h3: lf = '0;
            4'h4: lf = ~(ai & bi);
            4'h5: lf = ~bi;
            4'h6: lf = ai ^ bi;
            4'h7: lf = ai & ~bi;
            4'h8: lf = ~ai | bi;
            4'h9: lf = ~(ai ^ bi);
            4'hA: lf = bi;
            4'hB: lf = ai & bi;
            4'hC: lf = ones;
            4'hD: lf = ai | ~bi;
            4'hE: lf = ai | bi;
            default: lf = ai;
        endcase
        r.f      = mi ? lf : sum[W-1:0];
        r.co_bar = ~sum[W];
        r.aeqb   = (r.f == ones);
        r.ovf    = mi ? 1'b0 : (lo[W-1] ^ sum[W]);
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Called at a negedge; drives a request and returns after the accept edge at the next negedge with start low.
    task automatic issue(input logic [W-1:0] ai, input logic [W-1:0] bi, input logic [3:0] si,
                         input logic mi, input logic cib);
        a = ai; b = bi; s = si; m = mi; ci_bar = cib; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, output int n);
        n = 0;
        while (done !== 1'b1 && n < 20) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        chk({name, " latency"}, n, 4);
    endtask

    task automatic check_res(input string name, input res_t e);
        chk({name, " f"}, {16'h0, f}, {16'h0, e.f});
        chk({name, " co_bar"}, {31'h0, co_bar}, {31'h0, e.co_bar});
        chk({name, " aeqb"}, {31'h0, aeqb}, {31'h0, e.aeqb});
`ifdef JEFF_ALU181_OVF_EN
        chk({name, " ovf"}, {31'h0, ovf}, {31'h0, e.ovf});
`endif
    endtask

    vec_t vecs[10];

    initial begin
        int   n, pulses;
        res_t e;
        logic [W-1:0] ra, rb;
        logic [3:0]   rs;
        logic [3:0]   nib;

        vecs[0] = '{16'h1234, 16'h0FFF, 4'b1001, 1'b0, 1'b1, 16'h2233, 1'b1, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0001, 4'b1001, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0};
        vecs[2] = '{16'h5000, 16'h1234, 4'b0110, 1'b0, 1'b0, 16'h3DCC, 1'b0, 1'b0};
        vecs[3] = '{16'h00AA, 16'h00AA, 4'b0110, 1'b0, 1'b1, 16'hFFFF, 1'b1, 1'b1};
        vecs[4] = '{16'hF0F0, 16'hFF00, 4'b0110, 1'b1, 1'b1, 16'h0FF0, 1'b1, 1'b0};
        vecs[5] = '{16'hBBBB, 16'hBBBB, 4'b0000, 1'b1, 1'b1, 16'h4444, 1'b1, 1'b0};
        vecs[6] = '{16'h8001, 16'h0000, 4'b1100, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b1};
        vecs[7] = '{16'h1357, 16'h0000, 4'b0011, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0};
        vecs[8] = '{16'h0000, 16'h0000, 4'b1111, 1'b0, 1'b1, 16'hFFFF, 1'b1, 1'b1};
        vecs[9] = '{16'h8000, 16'h8000, 4'b1001, 1'b0, 1'b0, 16'h0001, 1'b0, 1'b0};

        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; s = '0; m = 1'b0; ci_bar = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset busy", {31'h0, busy}, 0);
        chk("reset done", {31'h0, done}, 0);
        chk("reset f", {16'h0, f}, 0);
        chk("reset co_bar", {31'h0, co_bar}, 1);
        chk("reset aeqb", {31'h0, aeqb}, 0);
`ifdef JEFF_ALU181_OVF_EN
        chk("reset ovf", {31'h0, ovf}, 0);
`endif
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            issue(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].m, vecs[i].ci_bar);
            chk($sformatf("vec%0d busy", i), {31'h0, busy}, 1);
            wait_done($sformatf("vec%0d", i), n);
            e.f = vecs[i].ef; e.co_bar = vecs[i].eco_bar; e.aeqb = vecs[i].eaeqb;
            e.ovf = model(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].m, vecs[i].ci_bar).ovf;
            check_res($sformatf("vec%0d", i), e);
            @(negedge clk);
            chk($sformatf("vec%0d done pulse", i), {31'h0, done}, 0);
            chk($sformatf("vec%0d idle busy", i), {31'h0, busy}, 0);
        end

        // All 16 logic functions on one nibble, replicated across every slice
        for (int k = 0; k < 16; k++) begin
            nib = 4'($urandom_range(0, 15));
            ra  = {4{nib}};
            nib = 4'($urandom_range(0, 15));
            rb  = {4{nib}};
            rs  = 4'(k);
            issue(ra, rb, rs, 1'b1, 1'($urandom_range(0, 1)));
            wait_done($sformatf("logic s=%0h", k), n);
            e = model(ra, rb, rs, 1'b1, ci_bar);
            check_res($sformatf("logic s=%0h a=%0h b=%0h", k, ra, rb), e);
        end

        // Randomized back-to-back ops: each new start lands in the previous done cycle
        for (int k = 0; k < 40; k++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            if (k % 8 == 0) begin ra = 16'h7FFF; rb = 16'h0001; end
            if (k % 8 == 1) begin ra = 16'hFFFF; rb = 16'h0000; end
            rs = 4'($urandom_range(0, 15));
            issue(ra, rb, rs, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            wait_done($sformatf("rand%0d", k), n);
            e = model(ra, rb, rs, m, ci_bar);
            check_res($sformatf("rand%0d s=%0h m=%0d a=%0h b=%0h", k, rs, m, ra, rb), e);
        end

        // start during RUN is ignored, then a start in the done cycle is accepted
        issue(16'h1111, 16'h2222, 4'b1001, 1'b0, 1'b1);
        a = 16'hFFFF; b = 16'hFFFF; s = 4'b0000; m = 1'b1; ci_bar = 1'b0; start = 1'b1;
        repeat (2) @(negedge clk);
        start = 1'b0;
        n = 2;
        while (done !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("ignored start latency", n, 4);
        chk("ignored start f", {16'h0, f}, 32'h3333);
        chk("ignored start co_bar", {31'h0, co_bar}, 1);
        issue(16'h0F0F, 16'h0101, 4'b1001, 1'b0, 1'b1);
        wait_done("back-to-back", n);
        chk("back-to-back f", {16'h0, f}, 32'h1010);

        // Reset in the second RUN cycle aborts with no done pulse
        @(negedge clk);
        issue(16'h1234, 16'h4321, 4'b1001, 1'b0, 1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort busy", {31'h0, busy}, 0);
        chk("abort f", {16'h0, f}, 0);
        chk("abort co_bar", {31'h0, co_bar}, 1);
        chk("abort done", {31'h0, done}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (done === 1'b1) pulses++;
        end
        chk("abort no done", pulses, 0);
        chk("abort idle busy", {31'h0, busy}, 0);

`ifdef JEFF_ALU181_OVF_EN
        issue(16'h7FFF, 16'h0001, 4'b1001, 1'b0, 1'b1);
        wait_done("ovf", n);
        chk("ovf 7FFF+1", {31'h0, ovf}, 1);
        chk("ovf f", {16'h0, f}, 32'h8000);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
